// File: rtl/huff_stream_ctrl_if.sv
// huff_stream_ctrl_if: stream-input, decoder and symbol-output handshakes of huff_stream_ctrl
// Ports (master = controller side):
//   in_data/in_valid/in_ready      packed MSB-first stream words
//   dec_rst_n/dec_data/dec_load    decoder reset, 6-bit window and load strobe
//   dec_ready/dec_len/dec_sym      decoder result: ready pulse, symbol length, symbol
//   sym_data/sym_valid/sym_ready   decoded symbol output with backpressure
interface huff_stream_ctrl_if #(parameter int IN_W = 16);
    logic [IN_W-1:0] in_data;
    logic            in_valid, in_ready;
    logic            dec_rst_n, dec_load, dec_ready;
    logic [5:0]      dec_data;
    logic [3:0]      dec_len, dec_sym;
    logic [3:0]      sym_data;
    logic            sym_valid, sym_ready;
    modport master (
        input  in_data, in_valid, dec_ready, dec_len, dec_sym, sym_ready,
        output in_ready, dec_rst_n, dec_data, dec_load, sym_data, sym_valid
    );
    modport slave (
        output in_data, in_valid, dec_ready, dec_len, dec_sym, sym_ready,
        input  in_ready, dec_rst_n, dec_data, dec_load, sym_data, sym_valid
    );
endinterface

// File: rtl/huff_stream_ctrl.sv
// huff_stream_ctrl: sequences a packed bitstream into a 6-bit-window Huffman decoder
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle pulse starting a stream (honoured in IDLE/DONE/ERR)
//   cfg_bit_len     total encoded bits of the stream, sampled on start
//   bus             stream input, decoder and symbol output handshakes (master side)
//   busy/done/err   stream active, stream finished, overrun or decoder timeout
//   sym_count       symbols emitted in the current stream
module huff_stream_ctrl #(
    parameter int IN_W    = 16,
    parameter int BUF_W   = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_bit_len,
    huff_stream_ctrl_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] sym_count
);
    localparam int AW = $clog2(BUF_W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [3:0] {IDLE, DRST, FILL1, FILL2, WAIT_SYM, EMIT, FEED, DONE, ERR} state_t;
    state_t           state;
    logic [BUF_W-1:0] bits_q, bits_n;
    logic [AW-1:0]    avail, avail_n, rem, after;
    logic [LEN_W:0]   words, words_lim, sum;
    logic [LEN_W-1:0] bit_len, consumed;
    logic [3:0]       len_q;
    logic [TW-1:0]    tmo;
    logic             exhausted, win_ok, fill, take;

    assign busy         = !(state inside {IDLE, DONE, ERR});
    assign done         = state == DONE;
    assign err          = state == ERR;
    assign exhausted    = words == words_lim;
    assign bus.in_ready = busy && avail <= AW'(BUF_W - IN_W) && !exhausted;
    assign take         = bus.in_valid && bus.in_ready;
    assign win_ok       = avail >= AW'(6) || exhausted;
    assign fill         = (state inside {FILL1, FILL2, FEED}) && win_ok;
    // WAIT_SYM checks the incoming length, EMIT commits the captured one
    assign sum          = {1'b0, consumed} + (LEN_W+1)'(state == EMIT ? len_q : bus.dec_len);

    // Buffer is left-justified: removal shifts out the top, a new word lands just below the survivors
    always_comb begin
        rem     = !fill ? '0 : state == FEED ? AW'(len_q) : AW'(6);
        after   = avail > rem ? avail - rem : '0;
        bits_n  = (bits_q << rem) | (take ? {bus.in_data, {(BUF_W-IN_W){1'b0}}} >> after : '0);
        avail_n = after + (take ? AW'(IN_W) : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bits_q        <= '0;
            avail         <= '0;
            words         <= '0;
            words_lim     <= '0;
            bit_len       <= '0;
            consumed      <= '0;
            len_q         <= '0;
            tmo           <= '0;
            sym_count     <= '0;
            bus.dec_rst_n <= 1'b1;
            bus.dec_data  <= '0;
            bus.dec_load  <= 1'b0;
            bus.sym_data  <= '0;
            bus.sym_valid <= 1'b0;
        end else begin
            bits_q       <= bits_n;
            avail        <= avail_n;
            if (take) words <= words + 1'b1;
            bus.dec_load <= fill;
            if (fill) bus.dec_data <= bits_q[BUF_W-1 -: 6];
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    bit_len       <= cfg_bit_len;
                    words_lim     <= ((LEN_W+1)'(cfg_bit_len) + (LEN_W+1)'(IN_W - 1)) / (LEN_W+1)'(IN_W);
                    words         <= '0;
                    bits_q        <= '0;
                    avail         <= '0;
                    consumed      <= '0;
                    sym_count     <= '0;
                    bus.dec_rst_n <= cfg_bit_len == '0;
                    state         <= cfg_bit_len == '0 ? DONE : DRST;
                end
                DRST: begin
                    bus.dec_rst_n <= 1'b1;
                    state         <= FILL1;
                end
                FILL1: if (win_ok) state <= FILL2;
                FILL2, FEED: if (win_ok) state <= WAIT_SYM;
                WAIT_SYM: begin
                    tmo <= tmo + 1'b1;
                    if (bus.dec_ready || tmo == TW'(TIMEOUT - 1)) tmo <= '0;
                    if (bus.dec_ready && sum <= {1'b0, bit_len}) begin
                        bus.sym_data  <= bus.dec_sym;
                        bus.sym_valid <= 1'b1;
                        len_q         <= bus.dec_len;
                        state         <= EMIT;
                    end else if (bus.dec_ready || tmo == TW'(TIMEOUT - 1)) state <= ERR;
                end
                EMIT: if (bus.sym_ready) begin
                    bus.sym_valid <= 1'b0;
                    sym_count     <= sym_count + 1'b1;
                    consumed      <= sum[LEN_W-1:0];
                    state         <= sum == {1'b0, bit_len} ? DONE : FEED;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
